// File: rtl/cellrv32_package.sv
// Shared types and default sizing for the vector rename controller.
package cellrv32_package;

    // Default RAT / physical register file sizing.
    localparam int unsigned VRN_ARCH_REGS_C = 32;
    localparam int unsigned VRN_PHYS_REGS_C = 64;

    // Rename controller FSM states.
    typedef enum logic [1:0] {
        VRN_INIT  = 2'b00,
        VRN_RUN   = 2'b01,
        VRN_FLUSH = 2'b10
    } vrename_state_t;

endpackage

// File: rtl/vrename_freelist.sv
// Circular free list of physical register IDs. One write port shared by the
// fill (load) path and the release (push) path, one pop port at the head,
// synchronous clear of pointers and count. Writes into a full list are dropped.
module vrename_freelist #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned PW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          load_en_i,
    input  logic [PW-1:0] load_data_i,
    input  logic          push_i,
    input  logic [PW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [PW-1:0] head_o,
    output logic [PW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned CW = PW + 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0] mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_en;
    logic          rd_en;
    logic [PW-1:0] wr_data;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    // Head reads the stored entry, so a same-cycle push is never visible here.
    assign head_o  = mem_q[head_q];

    // Write/pop qualification and pointer/count next state.
    always_comb begin
        wr_en   = (load_en_i | push_i) & ~full_o;
        wr_data = load_en_i ? load_data_i : push_data_i;
        rd_en   = pop_i & ~empty_o;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clr_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (rd_en) begin
                head_d = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
            end
            if (wr_en) begin
                tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents need no reset since count gates every read.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !clr_i && wr_en) begin
            mem_q[tail_q] <= wr_data;
        end
    end

endmodule

// File: rtl/vrename_ctrl.sv
// Vector rename controller: owns the physical register free list, renames
// decode requests against the RAT and sequences RAT reconfiguration.
// Optional feature macro: VRENAME_STALL_CNT_EN adds a saturating 32-bit
// stall counter on stall_cnt_o.
module vrename_ctrl
    import cellrv32_package::*;
#(
    parameter int unsigned ARCH_REGS = VRN_ARCH_REGS_C,
    parameter int unsigned PHYS_REGS = VRN_PHYS_REGS_C,
    parameter int unsigned PW        = $clog2(PHYS_REGS)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         rn_valid_i,
    output logic                         rn_ready_o,
    input  logic [$clog2(ARCH_REGS)-1:0] rn_dst_i,
    input  logic [$clog2(ARCH_REGS)-1:0] rn_src1_i,
    input  logic [$clog2(ARCH_REGS)-1:0] rn_src2_i,
    output logic [PW-1:0]                rn_pdst_o,
    output logic [PW-1:0]                rn_pold_o,
    output logic                         rn_pold_valid_o,
    output logic [PW-1:0]                rn_psrc1_o,
    output logic [PW-1:0]                rn_psrc2_o,
    input  logic                         rel_valid_i,
    input  logic [PW-1:0]                rel_preg_i,
    input  logic                         cfg_req_i,
    output logic                         cfg_ack_o,
    output logic                         rat_reconfigure_o,
    output logic [$clog2(ARCH_REGS)-1:0] rat_write_addr_o,
    output logic [PW-1:0]                rat_write_data_o,
    output logic                         rat_write_en_o,
    output logic [$clog2(ARCH_REGS)-1:0] rat_read_addr_1_o,
    output logic [$clog2(ARCH_REGS)-1:0] rat_read_addr_2_o,
    output logic [$clog2(ARCH_REGS)-1:0] rat_read_addr_3_o,
    input  logic [PW-1:0]                rat_read_data_1_i,
    input  logic [PW-1:0]                rat_read_data_2_i,
    input  logic [PW-1:0]                rat_read_data_3_i,
    input  logic                         rat_remapped_1_i,
    output logic                         rel_overflow_o,
    output logic [PW:0]                  free_count_o
`ifdef VRENAME_STALL_CNT_EN
    ,
    output logic [31:0]                  stall_cnt_o
`endif
);

    // After reset the RAT holds the identity map, so only IDs above it are free.
    localparam logic [PW-1:0] RESET_FIRST_ID = PW'(ARCH_REGS);
    localparam logic [PW-1:0] LAST_ID        = PW'(PHYS_REGS - 1);

    vrename_state_t state_q, state_d;
    logic [PW-1:0]  fill_q, fill_d;
    logic           from_flush_q, from_flush_d;
    logic           ack_q, ack_d;
    logic           ovf_q, ovf_d;

    logic           fl_clr;
    logic           fl_load;
    logic           fl_push;
    logic           fl_pop;
    logic [PW-1:0]  fl_head;
    logic [PW:0]    fl_count;
    logic           fl_full;
    logic           fl_empty;
    logic           rn_fire;

    vrename_freelist #(
        .DEPTH (PHYS_REGS),
        .PW    (PW)
    ) u_freelist (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (fl_clr),
        .load_en_i   (fl_load),
        .load_data_i (fill_q),
        .push_i      (fl_push),
        .push_data_i (rel_preg_i),
        .pop_i       (fl_pop),
        .head_o      (fl_head),
        .count_o     (fl_count),
        .full_o      (fl_full),
        .empty_o     (fl_empty)
    );

    // FSM state, fill counter, ack pulse and sticky overflow registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= VRN_INIT;
            fill_q       <= RESET_FIRST_ID;
            from_flush_q <= 1'b0;
            ack_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            from_flush_q <= from_flush_d;
            ack_q        <= ack_d;
            ovf_q        <= ovf_d;
        end
    end

    // FSM next state: fill in INIT, serve renames in RUN, one-cycle FLUSH.
    always_comb begin
        state_d           = state_q;
        fill_d            = fill_q;
        from_flush_d      = from_flush_q;
        ack_d             = 1'b0;
        fl_load           = 1'b0;
        fl_clr            = 1'b0;
        rat_reconfigure_o = 1'b0;
        unique case (state_q)
            VRN_INIT: begin
                fl_load = 1'b1;
                fill_d  = fill_q + 1'b1;
                if (fill_q == LAST_ID) begin
                    state_d      = VRN_RUN;
                    ack_d        = from_flush_q;
                    from_flush_d = 1'b0;
                end
            end
            VRN_RUN: begin
                // The requester still holds cfg_req_i during the ack cycle.
                if (cfg_req_i && !ack_q) begin
                    state_d = VRN_FLUSH;
                end
            end
            VRN_FLUSH: begin
                rat_reconfigure_o = 1'b1;
                fl_clr            = 1'b1;
                fill_d            = '0;
                from_flush_d      = 1'b1;
                state_d           = VRN_INIT;
            end
            default: begin
                state_d = VRN_INIT;
            end
        endcase
    end

    // Rename handshake, RAT port wiring and release path.
    always_comb begin
        rn_ready_o        = (state_q == VRN_RUN) && !cfg_req_i && !fl_empty;
        rn_fire           = rn_valid_i && rn_ready_o;
        fl_pop            = rn_fire;
        fl_push           = rel_valid_i && (state_q == VRN_RUN);
        ovf_d             = ovf_q | (fl_push & fl_full);

        rn_pdst_o         = fl_head;
        rat_read_addr_1_o = rn_dst_i;
        rat_read_addr_2_o = rn_src1_i;
        rat_read_addr_3_o = rn_src2_i;
        rn_pold_o         = rat_read_data_1_i;
        rn_pold_valid_o   = rat_remapped_1_i;
        rn_psrc1_o        = rat_read_data_2_i;
        rn_psrc2_o        = rat_read_data_3_i;

        rat_write_en_o    = rn_fire;
        rat_write_addr_o  = rn_dst_i;
        rat_write_data_o  = fl_head;
    end

    assign cfg_ack_o      = ack_q;
    assign rel_overflow_o = ovf_q;
    assign free_count_o   = fl_count;

`ifdef VRENAME_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Count RUN cycles with a request that is not accepted, saturating.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if ((state_q == VRN_RUN) && rn_valid_i && !rn_ready_o &&
                     (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vrename_ctrl.sv
// Self-checking bench for vrename_ctrl: a behavioural RAT, a queue-based
// free-list model and an architectural map model.
module tb_vrename_ctrl;

    localparam int ARCH = 32;
    localparam int PHYS = 64;
    localparam int PW   = 6;
    localparam int AW   = 5;

    logic          clk;
    logic          rst;
    logic          rn_valid;
    logic          rn_ready;
    logic [AW-1:0] rn_dst, rn_src1, rn_src2;
    logic [PW-1:0] rn_pdst, rn_pold, rn_psrc1, rn_psrc2;
    logic          rn_pold_valid;
    logic          rel_valid;
    logic [PW-1:0] rel_preg;
    logic          cfg_req;
    logic          cfg_ack;
    logic          rat_reconfigure;
    logic [AW-1:0] rat_waddr, rat_raddr1, rat_raddr2, rat_raddr3;
    logic [PW-1:0] rat_wdata, rat_rdata1, rat_rdata2, rat_rdata3;
    logic          rat_wen;
    logic          rat_remapped1;
    logic          rel_overflow;
    logic [PW:0]   free_count;
`ifdef VRENAME_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    vrename_ctrl #(
        .ARCH_REGS (ARCH),
        .PHYS_REGS (PHYS),
        .PW        (PW)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .rn_valid_i        (rn_valid),
        .rn_ready_o        (rn_ready),
        .rn_dst_i          (rn_dst),
        .rn_src1_i         (rn_src1),
        .rn_src2_i         (rn_src2),
        .rn_pdst_o         (rn_pdst),
        .rn_pold_o         (rn_pold),
        .rn_pold_valid_o   (rn_pold_valid),
        .rn_psrc1_o        (rn_psrc1),
        .rn_psrc2_o        (rn_psrc2),
        .rel_valid_i       (rel_valid),
        .rel_preg_i        (rel_preg),
        .cfg_req_i         (cfg_req),
        .cfg_ack_o         (cfg_ack),
        .rat_reconfigure_o (rat_reconfigure),
        .rat_write_addr_o  (rat_waddr),
        .rat_write_data_o  (rat_wdata),
        .rat_write_en_o    (rat_wen),
        .rat_read_addr_1_o (rat_raddr1),
        .rat_read_addr_2_o (rat_raddr2),
        .rat_read_addr_3_o (rat_raddr3),
        .rat_read_data_1_i (rat_rdata1),
        .rat_read_data_2_i (rat_rdata2),
        .rat_read_data_3_i (rat_rdata3),
        .rat_remapped_1_i  (rat_remapped1),
        .rel_overflow_o    (rel_overflow),
        .free_count_o      (free_count)
`ifdef VRENAME_STALL_CNT_EN
        ,
        .stall_cnt_o       (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAT driven by the DUT: identity on reset, cleared on reconfigure.
    logic [PW-1:0] rat_m [ARCH];
    logic          rat_v [ARCH];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH; i++) begin
                rat_m[i] <= PW'(i);
                rat_v[i] <= 1'b1;
            end
        end else if (rat_reconfigure) begin
            for (int i = 0; i < ARCH; i++) begin
                rat_m[i] <= '0;
                rat_v[i] <= 1'b0;
            end
        end else if (rat_wen) begin
            rat_m[rat_waddr] <= rat_wdata;
            rat_v[rat_waddr] <= 1'b1;
        end
    end

    always_comb begin
        rat_rdata1    = rat_m[rat_raddr1];
        rat_rdata2    = rat_m[rat_raddr2];
        rat_rdata3    = rat_m[rat_raddr3];
        rat_remapped1 = rat_v[rat_raddr1];
    end

    // Reference model state.
    int fq[$];
    int ref_map [ARCH];
    bit ref_live [ARCH];
    bit model_run;
    bit model_ovf;
    int model_stall;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_after_reset();
        fq.delete();
        for (int i = ARCH; i < PHYS; i++) fq.push_back(i);
        for (int i = 0; i < ARCH; i++) begin
            ref_map[i]  = i;
            ref_live[i] = 1'b1;
        end
        model_ovf   = 1'b0;
        model_stall = 0;
        model_run   = 1'b0;
    endtask

    task automatic model_after_flush();
        fq.delete();
        for (int i = 0; i < PHYS; i++) fq.push_back(i);
        for (int i = 0; i < ARCH; i++) begin
            ref_map[i]  = 0;
            ref_live[i] = 1'b0;
        end
    endtask

    // One clock: drive at negedge, check combinational results, clock, check state.
    task automatic do_cycle(input bit v, input int dst, input int s1, input int s2,
                            input bit rl, input int rid, input bit cfg);
        bit exp_rdy;
        bit full;
        int head;
        logic [AW-1:0] a;
        @(negedge clk);
        a        = AW'(dst); rn_dst  = a;
        a        = AW'(s1);  rn_src1 = a;
        a        = AW'(s2);  rn_src2 = a;
        rn_valid  = v;
        rel_valid = rl;
        rel_preg  = PW'(rid);
        cfg_req   = cfg;
        #1;
        exp_rdy = model_run && !cfg && (fq.size() != 0);
        head    = (fq.size() != 0) ? fq[0] : 0;
        check("rn_ready", rn_ready, exp_rdy);
        if (v && exp_rdy) begin
            check("rn_pdst", rn_pdst, head);
            check("rn_pold", rn_pold, ref_map[dst]);
            check("rn_pold_valid", rn_pold_valid, ref_live[dst]);
            check("rn_psrc1", rn_psrc1, ref_map[s1]);
            check("rn_psrc2", rn_psrc2, ref_map[s2]);
            check("rat_write_en", rat_wen, 1);
            check("rat_write_addr", rat_waddr, dst);
            check("rat_write_data", rat_wdata, head);
        end else begin
            check("rat_write_en_idle", rat_wen, 0);
        end
        @(posedge clk);
        full = (fq.size() == PHYS);
        if (v && exp_rdy) begin
            void'(fq.pop_front());
            ref_map[dst]  = head;
            ref_live[dst] = 1'b1;
        end
        if (rl && model_run) begin
            if (full) model_ovf = 1'b1;
            else fq.push_back(rid);
        end
        if (v && model_run && !exp_rdy) model_stall++;
        #1;
        check("free_count", free_count, fq.size());
        check("rel_overflow", rel_overflow, model_ovf);
`ifdef VRENAME_STALL_CNT_EN
        check("stall_cnt", stall_cnt, model_stall);
`endif
    endtask

    task automatic rename(input int dst);
        do_cycle(1'b1, dst, $urandom_range(0, ARCH - 1), $urandom_range(0, ARCH - 1),
                 1'b0, 0, 1'b0);
    endtask

    task automatic release_id(input int rid);
        do_cycle(1'b0, 0, 0, 0, 1'b1, rid, 1'b0);
    endtask

    initial begin
        int stall0;
        int last_pdst;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        rn_valid  = 1'b0;
        rn_dst    = '0;
        rn_src1   = '0;
        rn_src2   = '0;
        rel_valid = 1'b0;
        rel_preg  = '0;
        cfg_req   = 1'b0;
        model_after_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", rn_ready, 0);
        check("rst_wen", rat_wen, 0);
        check("rst_reconfigure", rat_reconfigure, 0);
        check("rst_ack", cfg_ack, 0);
        check("rst_overflow", rel_overflow, 0);
        check("rst_free_count", free_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset fill lasts PHYS-ARCH cycles and gives no ack.
        repeat (PHYS - ARCH - 1) @(posedge clk);
        #1;
        check("init_not_ready", rn_ready, 0);
        @(posedge clk);
        #1;
        check("init_done_count", free_count, PHYS - ARCH);
        check("init_done_ready", rn_ready, 1);
        check("init_no_ack", cfg_ack, 0);
        model_run = 1'b1;

        // Back-to-back renames of the same register.
        rename(3);
        check("b2b_map", ref_map[3], 32);
        rename(3);
        check("b2b_second_pdst", ref_map[3], 33);

        // Drain the free list.
        while (fq.size() != 0) rename($urandom_range(0, ARCH - 1));
        rename(4);
        // Release 7 alongside a pending request, then accept it.
        do_cycle(1'b1, 4, 1, 2, 1'b1, 7, 1'b0);
        do_cycle(1'b1, 4, 1, 2, 1'b0, 0, 1'b0);
        check("after_release_map", ref_map[4], 7);

        // Randomised mix of renames and releases.
        for (int i = 0; i < 150; i++) begin
            do_cycle(($urandom_range(0, 9) < 7), $urandom_range(0, ARCH - 1),
                     $urandom_range(0, ARCH - 1), $urandom_range(0, ARCH - 1),
                     $urandom_range(0, 1) == 1, $urandom_range(0, PHYS - 1), 1'b0);
        end

        // Simultaneous pop and push at count 10; released ID wraps to the head last.
        while (fq.size() > 10) rename($urandom_range(0, ARCH - 1));
        while (fq.size() < 10) release_id($urandom_range(0, PHYS - 1));
        do_cycle(1'b1, 6, 1, 2, 1'b1, 42, 1'b0);
        check("simul_count", free_count, 10);
        for (int i = 0; i < 10; i++) begin
            rename(8);
        end
        last_pdst = ref_map[8];
        check("wrapped_head", last_pdst, 42);

        // Reconfigure: request in the same cycle as a rename is not accepted.
        release_id(11);
        do_cycle(1'b1, 5, 1, 2, 1'b0, 0, 1'b1);
        model_run = 1'b0;
        check("flush_reconfigure", rat_reconfigure, 1);
        check("flush_ack", cfg_ack, 0);
        @(negedge clk);
        rn_valid = 1'b0;
        @(posedge clk);
        #1;
        check("init_reconfigure_low", rat_reconfigure, 0);
        check("init_count_cleared", free_count, 0);
        repeat (PHYS - 1) @(posedge clk);
        #1;
        check("init_no_early_ack", cfg_ack, 0);
        check("init_partial_count", free_count, PHYS - 1);
        @(posedge clk);
        #1;
        check("cfg_ack_pulse", cfg_ack, 1);
        check("cfg_free_count", free_count, PHYS);
        check("cfg_ack_not_ready", rn_ready, 0);
        @(negedge clk);
        cfg_req = 1'b0;
        model_after_flush();
        model_run = 1'b1;
        @(posedge clk);
        #1;
        check("ack_one_cycle", cfg_ack, 0);
        check("no_reflush", rat_reconfigure, 0);

        // First rename after reconfigure sees a cleared RAT.
        rename(12);
        check("post_cfg_pdst", ref_map[12], 0);

        // Release into a full list sets the sticky overflow.
        release_id(20);
        release_id(21);
        check("overflow_set", rel_overflow, 1);
        rename(13);
        release_id(22);
        check("overflow_sticky", rel_overflow, 1);

        // Drain then stall five cycles.
        while (fq.size() != 0) rename($urandom_range(0, ARCH - 1));
        stall0 = model_stall;
        for (int i = 0; i < 5; i++) rename(2);
`ifdef VRENAME_STALL_CNT_EN
        check("stall_delta", stall_cnt - 32'(stall0), 5);
`endif

        // Reset during INIT restarts the reset fill.
        release_id(30);
        do_cycle(1'b0, 0, 0, 0, 1'b0, 0, 1'b1);
        model_run = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst     = 1'b1;
        cfg_req = 1'b0;
        @(posedge clk);
        #1;
        check("midinit_rst_count", free_count, 0);
        check("midinit_rst_overflow", rel_overflow, 0);
        check("midinit_rst_ready", rn_ready, 0);
`ifdef VRENAME_STALL_CNT_EN
        check("midinit_rst_stall", stall_cnt, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        model_after_reset();
        repeat (PHYS - ARCH - 1) @(posedge clk);
        #1;
        check("refill_not_ready", rn_ready, 0);
        @(posedge clk);
        #1;
        check("refill_count", free_count, PHYS - ARCH);
        check("refill_no_ack", cfg_ack, 0);
        model_run = 1'b1;
        rename(9);
        rename(9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
